clksel_ctrl: RTL and testbench
==============================

Name: clksel_ctrl

Overview:
Single-clock controller that generates the registered `sel` input of the glitch-free clock switch, `clkshift`. It accepts clock-switch requests through a valid/ready handshake and holds `sel` stable for a settle window, long enough for the switch's two synchroniser stages to follow. It reports completion with a one-cycle pulse, then enforces a minimum dwell time before it accepts another request.

Parameters:
- SETTLE_CYCLES, 4, cycles from a `sel` change to `switch_done`. Legal range ≥1.
- DWELL_CYCLES, 8, minimum cycles after `switch_done` before `req_ready` reasserts. Legal range ≥0.
- CNT_W, 8, width of the internal down-counter. Must satisfy 2^CNT_W > max(SETTLE_CYCLES, DWELL_CYCLES).

Ports:
- clk, input, 1, block clock; all logic on posedge.
- rst, input, 1, synchronous, active-low reset.
- req_valid, input, 1, switch request present.
- req_sel, input, 1, requested clock: 0 selects clk0, 1 selects clk1.
- req_ready, output, 1, request accepted on an edge where req_valid && req_ready.
- sel, output, 1, registered select; drives the clock switch's `sel` input.
- busy, output, 1, high in SETTLE or DWELL.
- switch_done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, sel=0, counter=0, switch_done=0.
  - req_ready=0 and busy=0 while rst is low; takes priority over everything else.
  - Reset mid-SETTLE or mid-DWELL aborts the operation and returns sel to 0; no switch_done is issued.
- States:
  - IDLE: req_ready=1 (subject to the optional lock), busy=0.
  - SETTLE: req_ready=0, busy=1.
  - DWELL: req_ready=0, busy=1.
- IDLE, accept edge with req_sel != sel:
  - sel<=req_sel and state<=SETTLE on that same edge.
  - counter<=SETTLE_CYCLES-1.
- IDLE, accept edge with req_sel == sel:
  - No switch; stay in IDLE; no dwell.
  - switch_done<=1 on the accept edge, so the pulse is high for the following cycle.
- SETTLE, each edge:
  - If counter!=0: decrement.
  - If counter==0: switch_done<=1.
    - If DWELL_CYCLES>0: state<=DWELL, counter<=DWELL_CYCLES-1.
    - Otherwise: state<=IDLE.
- DWELL, each edge:
  - If counter!=0: decrement.
  - Else: state<=IDLE.
- Timing for an accept on edge E:
  - switch_done high between edges E+SETTLE_CYCLES and E+SETTLE_CYCLES+1.
  - req_ready high again after edge E+SETTLE_CYCLES+DWELL_CYCLES.
- switch_done:
  - Registered; high for exactly one cycle per accepted request.
  - Cleared on the next edge unless a new pulse is being generated.
- Requests while not ready:
  - req_valid while req_ready==0 is not consumed.
  - The requester must hold req_valid and req_sel stable until accepted; the block neither drops nor queues.
- Invariants:
  - sel changes only on an accept edge or on reset; it never changes in SETTLE or DWELL.
  - At most one outstanding request.
  - The counter never wraps: each load happens only from a state transition.

Optional Feature:
- Macro: CLKSEL_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While lock==1, req_ready is forced to 0 in IDLE, so requests stall rather than being dropped.
  - Lock does not abort SETTLE or DWELL; a lock raised mid-operation takes effect on return to IDLE.
- Undefined:
  - No `lock` port; behaviour is identical to lock==0.

Test Plan:
- Reset values: hold rst=0 for 3 cycles with req_valid=1 → sel=0, req_ready=0, busy=0, switch_done=0 throughout; req_ready=1 on the first cycle after release.
- Switch 0→1 (defaults): req_valid=1, req_sel=1 accepted at edge E →
  - sel=1 after E; busy=1 after E; switch_done high only between E+4 and E+5;
  - req_ready=0 until after E+12, then 1; busy=0 after E+12.
- Same-select request: sel=0, req_valid=1, req_sel=0 accepted at E → sel stays 0, switch_done high one cycle after E, busy never asserts, req_ready stays 1.
- Back-to-back requests: a second request (req_sel=0) is held valid from E+1 →
  - not accepted before E+12; accepted at edge E+13;
  - sel=0 after E+13; switch_done after E+17.
- Reset mid-SETTLE: drive rst=0 at edge E+2 of a 0→1 switch → sel=0, busy=0 after that edge; no switch_done pulse; a fresh request is accepted normally after release.
- CLKSEL_LOCK_EN: lock=1 with a request pending for 10 cycles → no accept, sel unchanged; drop lock → accept on the next edge; lock=1 raised during SETTLE → switch_done still issued at E+4.

Source files
------------

// File: rtl/clksel_ctrl.sv
// -----------------------------------------------------------------------------
// clksel_ctrl
//
// Purpose:
//   Generates the registered `sel` input of the glitch-free clock switch
//   (clkshift). Switch requests arrive on a valid/ready handshake. After a
//   change, `sel` is held stable for SETTLE_CYCLES so the switch's two
//   synchroniser stages can follow. Completion is reported with a one-cycle
//   `switch_done` pulse. A further DWELL_CYCLES must pass before the next
//   request is accepted.
//
// Parameters:
//   SETTLE_CYCLES : cycles from a `sel` change to `switch_done` (>= 1)
//   DWELL_CYCLES  : minimum cycles after `switch_done` before ready (>= 0)
//   CNT_W         : down-counter width, 2**CNT_W > max(SETTLE, DWELL)
//
// Ports:
//   clk         in   block clock, all logic on posedge
//   rst         in   synchronous reset, active low
//   lock        in   (CLKSEL_LOCK_EN only) holds off acceptance in IDLE
//   req_valid   in   switch request present
//   req_sel     in   requested clock: 0 = clk0, 1 = clk1
//   req_ready   out  request accepted on an edge with req_valid && req_ready
//   sel         out  registered select to the clock switch
//   busy        out  high in SETTLE or DWELL
//   switch_done out  one-cycle completion pulse
//
// Optional feature:
//   Define CLKSEL_LOCK_EN to add the `lock` input. While lock is high the
//   block stalls requests in IDLE. It does not abort an operation already in
//   progress. Without the macro the block behaves as if lock were tied low.
// -----------------------------------------------------------------------------
module clksel_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 8,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
`ifdef CLKSEL_LOCK_EN
  input  logic lock,
`endif
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic busy,
  output logic switch_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  // The counter is loaded with N-1 so that N edges are spent in the state.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD  =
      (DWELL_CYCLES > 0) ? CNT_W'(DWELL_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_reg, state_next;
  logic             sel_reg, sel_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             lock_int;
  logic             accept;

`ifdef CLKSEL_LOCK_EN
  assign lock_int = lock;
`else
  assign lock_int = 1'b0;
`endif

  // Ready and busy are gated by rst so both read low for the whole time
  // reset is held, even before the first reset edge clears the state.
  assign req_ready   = rst && (state_reg == IDLE) && !lock_int;
  assign busy        = rst && (state_reg != IDLE);
  assign accept      = req_valid && req_ready;
  assign sel         = sel_reg;
  assign switch_done = done_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_sel != sel_reg) begin
            // sel only ever changes here, on the accept edge itself.
            sel_next   = req_sel;
            state_next = SETTLE;
            cnt_next   = SETTLE_LOAD;
          end else begin
            // Already on the requested clock: acknowledge without settle/dwell.
            done_next = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          done_next = 1'b1;
          if (DWELL_CYCLES > 0) begin
            state_next = DWELL;
            cnt_next   = DWELL_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DWELL: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clksel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clksel_ctrl
//
// Purpose:
//   Directed test of clksel_ctrl with default parameters (SETTLE=4, DWELL=8).
//   It covers reset values, same-select requests, a 0->1 switch with a
//   back-to-back 1->0 request held pending, reset in the middle of SETTLE and a
//   fresh request afterwards. With CLKSEL_LOCK_EN defined it also covers the
//   lock stall and a lock raised during SETTLE.
//
//   The bench drives inputs and samples outputs on the negative clock edge.
//   Edge E denotes the first posedge after a request is presented.
// -----------------------------------------------------------------------------
module tb_clksel_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic sel;
  logic busy;
  logic switch_done;
`ifdef CLKSEL_LOCK_EN
  logic lock;
`endif

  int check_cnt = 0;
  int error_cnt = 0;

  always #5 clk = ~clk;

  clksel_ctrl #(
    .SETTLE_CYCLES(4),
    .DWELL_CYCLES (8),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CLKSEL_LOCK_EN
    .lock       (lock),
`endif
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .sel        (sel),
    .busy       (busy),
    .switch_done(switch_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b1;
    req_sel   = 1'b1;
`ifdef CLKSEL_LOCK_EN
    lock      = 1'b0;
`endif

    // ---------------- reset values ----------------
    $display("txn: reset held 3 cycles with req_valid=1");
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_sel_%0d", i), 32'(sel), 32'd0);
      check($sformatf("rst_ready_%0d", i), 32'(req_ready), 32'd0);
      check($sformatf("rst_busy_%0d", i), 32'(busy), 32'd0);
      check($sformatf("rst_done_%0d", i), 32'(switch_done), 32'd0);
      step();
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);

    // ---------------- same-select request ----------------
    $display("txn: same-select request sel=0 req_sel=0");
    step();
    req_valid = 1'b1;
    req_sel   = 1'b0;
    #1;
    check("same_ready_pre", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("same_done", 32'(switch_done), 32'd1);
    check("same_sel", 32'(sel), 32'd0);
    check("same_busy", 32'(busy), 32'd0);
    check("same_ready", 32'(req_ready), 32'd1);
    step();
    check("same_done_clr", 32'(switch_done), 32'd0);
    check("same_busy2", 32'(busy), 32'd0);

    // ---------- switch 0->1 with a back-to-back 1->0 held from E+1 ----------
    $display("txn: switch 0->1, then back-to-back request to 0");
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();                       // edge E: 0->1 accepted
    req_sel = 1'b0;               // second request held valid from E+1
    check("sw_sel_E", 32'(sel), 32'd1);
    check("sw_busy_E", 32'(busy), 32'd1);
    check("sw_ready_E", 32'(req_ready), 32'd0);
    check("sw_done_E", 32'(switch_done), 32'd0);
    for (int i = 1; i <= 25; i++) begin
      step();                     // edge E+i has passed
      check($sformatf("b2b_sel_%0d", i), 32'(sel), (i >= 13) ? 32'd0 : 32'd1);
      check($sformatf("b2b_done_%0d", i), 32'(switch_done),
            (i == 4 || i == 17) ? 32'd1 : 32'd0);
      check($sformatf("b2b_busy_%0d", i), 32'(busy),
            ((i < 12) || (i >= 13 && i < 25)) ? 32'd1 : 32'd0);
      check($sformatf("b2b_ready_%0d", i), 32'(req_ready),
            (i == 12 || i == 25) ? 32'd1 : 32'd0);
      if (i == 13) req_valid = 1'b0;
    end

    // ---------------- reset mid-SETTLE ----------------
    $display("txn: switch 0->1 aborted by reset at E+2");
    req_valid = 1'b1;
    req_sel   = 1'b1;
    step();                       // edge E
    req_valid = 1'b0;
    check("abort_sel_E", 32'(sel), 32'd1);
    step();                       // edge E+1
    rst = 1'b0;
    #1;
    check("abort_busy_rstlow", 32'(busy), 32'd0);
    check("abort_ready_rstlow", 32'(req_ready), 32'd0);
    step();                       // edge E+2 with reset low
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(switch_done), 32'd0);
    rst = 1'b1;
    for (int i = 3; i <= 8; i++) begin
      step();
      check($sformatf("abort_nodone_%0d", i), 32'(switch_done), 32'd0);
      check($sformatf("abort_idle_sel_%0d", i), 32'(sel), 32'd0);
      check($sformatf("abort_idle_busy_%0d", i), 32'(busy), 32'd0);
    end

    $display("txn: fresh switch 0->1 after reset release");
    req_valid = 1'b1;
    req_sel   = 1'b1;
    #1;
    check("fresh_ready_pre", 32'(req_ready), 32'd1);
    step();                       // edge E
    req_valid = 1'b0;
    check("fresh_sel", 32'(sel), 32'd1);
    check("fresh_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("fresh_done_%0d", i), 32'(switch_done), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("fresh_busy_%0d", i), 32'(busy), (i < 12) ? 32'd1 : 32'd0);
    end

`ifdef CLKSEL_LOCK_EN
    // ---------------- lock ----------------
    $display("txn: lock stalls a pending 1->0 request for 10 cycles");
    lock      = 1'b1;
    req_valid = 1'b1;
    req_sel   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("lock_ready_%0d", i), 32'(req_ready), 32'd0);
      check($sformatf("lock_sel_%0d", i), 32'(sel), 32'd1);
      check($sformatf("lock_busy_%0d", i), 32'(busy), 32'd0);
    end
    lock = 1'b0;
    #1;
    check("unlock_ready", 32'(req_ready), 32'd1);
    step();                       // edge E: accepted
    req_valid = 1'b0;
    lock      = 1'b1;             // raised during SETTLE
    check("unlock_sel", 32'(sel), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("lockset_done_%0d", i), 32'(switch_done), (i == 4) ? 32'd1 : 32'd0);
      check($sformatf("lockset_busy_%0d", i), 32'(busy), (i < 12) ? 32'd1 : 32'd0);
    end
    check("lockset_ready_idle", 32'(req_ready), 32'd0);
    lock = 1'b0;
    #1;
    check("lockset_ready_unlock", 32'(req_ready), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
